// File: rtl/lbp_engine.sv
// lbp_engine
//   Streams an IMG_W x IMG_H 8-bit grayscale image from a read-only pixel
//   memory and writes the 8-bit Local Binary Pattern of every interior pixel
//   to a result memory, in raster order. Border pixels are never written.
//
// Ports
//   clk         system clock, posedge logic
//   reset       asynchronous active-low reset
//   gray_ready  pixel memory may be read this cycle
//   gray_req    registered read request
//   gray_addr   registered read address, row*IMG_W + col
//   gray_data   pixel for the previous cycle's request
//   lbp_valid   result write strobe (memory captures on negedge)
//   lbp_addr    result address, row*IMG_W + col
//   lbp_data    LBP code
//   finish      whole frame written; held until reset
module lbp_engine #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  // Image dimensions are powers of two, so an address is just {row, col}.
  localparam int CW = $clog2(IMG_W);
  localparam int RW = AW - CW;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 2);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 2);

  typedef enum logic [2:0] {IDLE, LOAD9, SHIFT3, WRITE, DONE} state_t;

  state_t        state, state_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [3:0]    cnt;        // requests issued in the current fetch phase
  logic [3:0]    slot;       // window slot of the request now in flight
  logic [7:0]    win [9];    // 3x3 window, row-major, win[4] is the centre

  logic          issue;
  logic [3:0]    issue_slot;
  logic [RW-1:0] req_row;
  logic [CW-1:0] req_col;
  logic [1:0]    dr, dc;
  logic [7:0]    code;

  // Bit i compares neighbour i (row-major, centre skipped) against the centre.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
    assign code[gi] = (win[(gi < 4) ? gi : gi + 1] >= win[4]);
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    dr         = 2'd0;
    dc         = 2'd0;
    issue_slot = cnt;
    req_row    = row;
    req_col    = col;

    case (state)
      IDLE:   if (gray_ready) state_next = LOAD9;
      // The phase ends one cycle after the last request, when its data lands.
      LOAD9:  if (cnt == 4'd9) state_next = WRITE;
              else if (gray_ready) issue = 1'b1;
      SHIFT3: if (cnt == 4'd3) state_next = WRITE;
              else if (gray_ready) issue = 1'b1;
      WRITE:  if (col == LAST_COL) state_next = (row == LAST_ROW) ? DONE : LOAD9;
              else state_next = SHIFT3;
      DONE:   state_next = DONE;
      default: state_next = IDLE;
    endcase

    if (state == SHIFT3) begin
      // New right column, top to bottom, into slots 2, 5, 8.
      issue_slot = 4'd3 * cnt + 4'd2;
      req_row    = row + RW'(cnt) - RW'(1);
      req_col    = col + CW'(1);
    end else begin
      // Full window, row-major from (row-1, col-1).
      dr         = (cnt >= 4'd6) ? 2'd2 : (cnt >= 4'd3) ? 2'd1 : 2'd0;
      dc         = 2'(cnt - 4'd3 * {2'b00, dr});
      req_row    = row + RW'(dr) - RW'(1);
      req_col    = col + CW'(dc) - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= RW'(1);
      col       <= CW'(1);
      cnt       <= 4'd0;
      slot      <= 4'd0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      for (int i = 0; i < 9; i++) win[i] <= 8'd0;
    end else begin
      state    <= state_next;
      gray_req <= issue;
      if (issue) begin
        gray_addr <= {req_row, req_col};
        slot      <= issue_slot;
        cnt       <= cnt + 4'd1;
      end
      // gray_data is only meaningful in the cycle after a request.
      if (gray_req) win[slot] <= gray_data;

      // No read is in flight during WRITE, so shifting cannot race a capture.
      if (state == WRITE) begin
        cnt <= 4'd0;
        if (state_next == SHIFT3) begin
          col    <= col + CW'(1);
          win[0] <= win[1];
          win[1] <= win[2];
          win[3] <= win[4];
          win[4] <= win[5];
          win[6] <= win[7];
          win[7] <= win[8];
        end else if (state_next == LOAD9) begin
          row <= row + RW'(1);
          col <= CW'(1);
        end
      end
    end
  end

  assign lbp_valid = (state == WRITE);
  assign lbp_addr  = lbp_valid ? {row, col} : '0;
  assign lbp_data  = lbp_valid ? code : 8'd0;
  assign finish    = (state == DONE);

endmodule

// File: tb/tb_lbp_engine.sv
// tb_lbp_engine
//   Scoreboard bench for lbp_engine on a 16x16 image. Each frame pushes the
//   expected (address, code) sequence into a queue; a negedge monitor acts as
//   the result memory and pops/compares on every write strobe.
module tb_lbp_engine;

  localparam int W      = 16;
  localparam int H      = 16;
  localparam int AW     = 8;
  localparam int NWR    = (W - 2) * (H - 2);
  localparam int BUDGET = NWR * 5 + (H - 2) * 10;
  localparam int LIMIT  = 5000;

  logic          clk;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  logic [7:0]    img [W*H];
  logic [7:0]    res [W*H];
  logic [AW+7:0] exp_q [$];
  int            tests;
  int            fails;
  int            wr_cnt;

  lbp_engine #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel memory: answers the current request before the next posedge;
  // junk otherwise so misuse of gray_data shows up.
  always @(negedge clk) gray_data = gray_req ? img[gray_addr] : 8'hA5;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result memory plus scoreboard monitor.
  always @(negedge clk) begin
    if (reset && lbp_valid) begin
      logic [AW+7:0] e;
      res[lbp_addr] = lbp_data;
      wr_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write: unexpected write addr=%0d data=%02h", lbp_addr, lbp_data);
      end else begin
        e = exp_q.pop_front();
        if ({lbp_addr, lbp_data} != e) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                   lbp_addr, lbp_data, e[AW+7:8], e[7:0]);
        end
      end
    end
  end

  function automatic logic [7:0] lbp_model(input int r, input int c);
    logic [7:0] g;
    logic [7:0] v;
    g    = img[r*W + c];
    v[0] = img[(r-1)*W + c-1] >= g;
    v[1] = img[(r-1)*W + c]   >= g;
    v[2] = img[(r-1)*W + c+1] >= g;
    v[3] = img[r*W + c-1]     >= g;
    v[4] = img[r*W + c+1]     >= g;
    v[5] = img[(r+1)*W + c-1] >= g;
    v[6] = img[(r+1)*W + c]   >= g;
    v[7] = img[(r+1)*W + c+1] >= g;
    return v;
  endfunction

  function automatic bit interior(input int a);
    int r, c;
    r = a / W;
    c = a % W;
    return (r >= 1 && r <= H-2 && c >= 1 && c <= W-2);
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < W*H; i++) img[i] = v;
  endtask

  task automatic fill_random();
    // Coarse levels make equal-valued neighbours common.
    for (int i = 0; i < W*H; i++) img[i] = 8'($urandom_range(0, 7) * 32);
  endtask

  task automatic push_expected();
    exp_q.delete();
    wr_cnt = 0;
    for (int i = 0; i < W*H; i++) res[i] = 8'd0;
    for (int r = 1; r <= H-2; r++)
      for (int c = 1; c <= W-2; c++)
        exp_q.push_back({AW'(r*W + c), lbp_model(r, c)});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_frame(input int hold, input bit toggle, input string tag);
    int cycles, viol, mism, bord;
    bit rdy;
    gray_ready = 1'b0;
    do_reset();
    push_expected();
    viol = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (gray_req || lbp_valid) viol++;
    end
    if (hold > 0) check({tag, "_idle_while_not_ready"}, viol, 0);
    viol = 0;
    cycles = 0;
    gray_ready = 1'b1;
    while (!finish && cycles < LIMIT) begin
      rdy = gray_ready;
      @(posedge clk); #1;
      cycles++;
      if (!rdy && gray_req) viol++;
      if (toggle) gray_ready = ($urandom_range(0, 3) != 0);
    end
    gray_ready = 1'b1;
    check({tag, "_finish"}, int'(finish), 1);
    if (!toggle) check({tag, "_cycle_budget"}, (cycles <= BUDGET) ? 0 : cycles, 0);
    check({tag, "_req_while_not_ready"}, viol, 0);
    check({tag, "_write_count"}, wr_cnt, NWR);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check({tag, "_finish_hold"}, int'({finish, lbp_valid, gray_req}), 4);
    mism = 0;
    bord = 0;
    for (int a = 0; a < W*H; a++) begin
      if (!interior(a) && res[a] != 8'd0) bord++;
      if (res[a] != (interior(a) ? lbp_model(a / W, a % W) : 8'd0)) mism++;
    end
    check({tag, "_border_untouched"}, bord, 0);
    check({tag, "_full_compare"}, mism, 0);
  endtask

  task automatic chk_px(input int r, input int c, input logic [7:0] e);
    check($sformatf("px_%0d_%0d", r, c), int'(res[r*W + c]), int'(e));
  endtask

  initial begin
    int  n;
    bit  hit;
    tests = 0;
    fails = 0;
    wr_cnt = 0;
    reset = 1'b0;
    gray_ready = 1'b0;
    fill(8'd100);
    repeat (2) @(posedge clk);
    #1 check("reset_outputs",
             int'({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}), 0);

    // Constant image: every interior code is all ones.
    run_frame(0, 1'b0, "const");
    chk_px(1, 1, 8'hFF);
    chk_px(W-2, H-2, 8'hFF);
    chk_px(0, 0, 8'h00);

    // Single dark pixel.
    fill(8'd100);
    img[5*W + 5] = 8'd50;
    run_frame(0, 1'b0, "dark");
    chk_px(5, 5, 8'hFF);
    chk_px(4, 4, 8'h7F);
    chk_px(4, 5, 8'hBF);
    chk_px(6, 6, 8'hFE);
    chk_px(5, 6, 8'hF7);

    // Single bright pixel.
    fill(8'd100);
    img[5*W + 5] = 8'd200;
    run_frame(0, 1'b0, "bright");
    chk_px(5, 5, 8'h00);
    chk_px(4, 4, 8'hFF);
    chk_px(6, 5, 8'hFF);

    // Random image with gray_ready dropping at random.
    fill_random();
    run_frame(0, 1'b1, "rand_stall");

    // Ready held low for 20 cycles after reset.
    fill(8'd100);
    run_frame(20, 1'b0, "hold20");

    // Abort mid-frame on the write of pixel (7,7), then rerun.
    fill_random();
    gray_ready = 1'b0;
    do_reset();
    push_expected();
    gray_ready = 1'b1;
    n = 0;
    hit = 1'b0;
    while (!hit && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (lbp_valid && lbp_addr == AW'(7*W + 7)) hit = 1'b1;
    end
    check("abort_reached_pixel", int'(hit), 1);
    #1 reset = 1'b0;
    #1 check("abort_outputs_zero",
             int'({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}), 0);
    gray_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    run_frame(0, 1'b0, "rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
